// File: rtl/doodle_pkg.sv
// Shared definitions for the jump-game platform field: default playfield
// geometry, LFSR seed/taps, the scan FSM state type and the initial layout.
package doodle_pkg;

  localparam logic [1:0]  ST_PLAY = 2'd2;

  localparam int unsigned NUM_PLAT_D    = 8;
  localparam int unsigned MAP_WIDTH_D   = 640;
  localparam int unsigned MAP_HEIGHT_D  = 480;
  localparam int unsigned PLAT_WIDTH_D  = 64;
  localparam int unsigned PLAT_HEIGHT_D = 8;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned LFSR_W  = 16;

  // x^16 + x^14 + x^13 + x^11 + 1, bit 15 is the x^16 term
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } pm_state_e;

  // Platform i starts stacked upward from just above the bottom edge.
  function automatic logic [9:0] init_y(int unsigned i, int unsigned map_h,
                                        int unsigned n);
    return 10'(map_h - 16 - i * (map_h / n));
  endfunction

  // Platform 0 is centred under the figure's spawn point; others are spread.
  function automatic logic [9:0] init_x(int unsigned i, int unsigned map_w,
                                        int unsigned plat_w);
    if (i == 0) return 10'((map_w - plat_w) / 2);
    return 10'((i * 149) % (map_w - plat_w));
  endfunction

endpackage

// File: rtl/plat_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying respawn x positions.
// Ports: clk, rst_n (async, active-low, loads the seed), rnd = low 10 bits.
module plat_lfsr
  import doodle_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] rnd
);

  logic [LFSR_W-1:0] lfsr_q;
  logic              fb;

  assign fb  = ^(lfsr_q & LFSR_TAPS);
  assign rnd = lfsr_q[9:0];

  // Steps every cycle regardless of game state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[LFSR_W-2:0], fb};
  end

endmodule

// File: rtl/platform_manager.sv
// Platform field owner: scrolls NUM_PLAT platforms by `advance` each frame,
// respawns those leaving the bottom, and reports landing (hit/floor).
// Ports: clk, rst_n, frame strobe, game state, figure pos/size/fly/spd_y,
//   advance; rd_idx -> rd_x/rd_y (combinational); hit, floor, busy, score.
// Optional: define PLAT_SCORE_EN for the saturating score register,
//   otherwise score is tied to zero.
module platform_manager
  import doodle_pkg::*;
#(
  parameter  int unsigned NUM_PLAT    = NUM_PLAT_D,
  parameter  int unsigned MAP_WIDTH   = MAP_WIDTH_D,
  parameter  int unsigned MAP_HEIGHT  = MAP_HEIGHT_D,
  parameter  int unsigned PLAT_WIDTH  = PLAT_WIDTH_D,
  parameter  int unsigned PLAT_HEIGHT = PLAT_HEIGHT_D,
  localparam int unsigned IDX_W       = $clog2(NUM_PLAT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame,
  input  logic [1:0]       state,
  input  logic [9:0]       pos_x,
  input  logic [9:0]       pos_y,
  input  logic [7:0]       fig_width,
  input  logic [7:0]       fig_height,
  input  logic             fly,
  input  logic [3:0]       spd_y,
  input  logic [3:0]       advance,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [9:0]       rd_x,
  output logic [9:0]       rd_y,
  output logic             hit,
  output logic [9:0]       floor,
  output logic             busy,
  output logic [15:0]      score
);

  localparam int unsigned SPAN = MAP_WIDTH - PLAT_WIDTH;

  pm_state_e st_q, st_d;

  logic [9:0]       plat_x [NUM_PLAT];
  logic [9:0]       plat_y [NUM_PLAT];
  logic [IDX_W-1:0] idx_q;
  logic             match_q;
  logic [9:0]       cand_q;

  logic [9:0] px_q, py_q;
  logic [7:0] fw_q, fh_q;
  logic       fly_q;
  logic [3:0] spd_q, adv_q;

  logic       playing;
  logic [9:0] rnd, resp_x, new_x, new_y;
  logic [10:0] ny, feet, top_hi;
  logic       wrap, hit_now;

  assign playing = (state == ST_PLAY);
  assign rd_x    = plat_x[rd_idx];
  assign rd_y    = plat_y[rd_idx];
  assign busy    = (st_q != IDLE);

  plat_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .rnd   (rnd)
  );

  // Fold the 10-bit random value into the legal platform x range.
  assign resp_x = (rnd <= 10'(SPAN)) ? rnd : rnd - 10'(SPAN);

  // Scroll/respawn and landing test for the platform under the scan index.
  always_comb begin
    ny      = 11'(plat_y[idx_q]) + 11'(adv_q);
    wrap    = (ny >= 11'(MAP_HEIGHT));
    new_y   = wrap ? 10'(ny - 11'(MAP_HEIGHT)) : ny[9:0];
    new_x   = wrap ? resp_x : plat_x[idx_q];
    feet    = 11'(py_q) + 11'(fh_q);
    top_hi  = 11'(new_y) + 11'(PLAT_HEIGHT) + 11'(spd_q);
    hit_now = !fly_q
           && (feet >= 11'(new_y)) && (feet <= top_hi)
           && (11'(px_q) + 11'(fw_q) > 11'(new_x))
           && (11'(px_q) < 11'(new_x) + 11'(PLAT_WIDTH));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  // FSM next state; leaving play aborts on the same edge.
  always_comb begin
    st_d = st_q;
    if (!playing) begin
      st_d = IDLE;
    end else begin
      case (st_q)
        IDLE:    if (frame) st_d = SCAN;
        SCAN:    if (idx_q == IDX_W'(NUM_PLAT - 1)) st_d = DONE;
        DONE:    st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end
  end

  // Platform field, frame latches and landing result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PLAT; i++) begin
        plat_x[i] <= init_x(i, MAP_WIDTH, PLAT_WIDTH);
        plat_y[i] <= init_y(i, MAP_HEIGHT, NUM_PLAT);
      end
      idx_q   <= '0;
      match_q <= 1'b0;
      cand_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      fw_q    <= '0;
      fh_q    <= '0;
      fly_q   <= 1'b0;
      spd_q   <= '0;
      adv_q   <= '0;
      hit     <= 1'b0;
      floor   <= '0;
    end else if (!playing) begin
      for (int unsigned i = 0; i < NUM_PLAT; i++) begin
        plat_x[i] <= init_x(i, MAP_WIDTH, PLAT_WIDTH);
        plat_y[i] <= init_y(i, MAP_HEIGHT, NUM_PLAT);
      end
      hit <= 1'b0;
    end else begin
      case (st_q)
        IDLE: if (frame) begin
          px_q    <= pos_x;
          py_q    <= pos_y;
          fw_q    <= fig_width;
          fh_q    <= fig_height;
          fly_q   <= fly;
          spd_q   <= spd_y;
          adv_q   <= advance;
          idx_q   <= '0;
          match_q <= 1'b0;
        end
        SCAN: begin
          plat_x[idx_q] <= new_x;
          plat_y[idx_q] <= new_y;
          if (hit_now && !match_q) begin
            match_q <= 1'b1;
            cand_q  <= new_y;
          end
          idx_q <= idx_q + 1'b1;
        end
        DONE: begin
          hit <= match_q;
          if (match_q) floor <= cand_q;
        end
        default: ;
      endcase
    end
  end

`ifdef PLAT_SCORE_EN
  logic [16:0] score_sum;
  assign score_sum = {1'b0, score} + 17'(adv_q);

  // Accumulated height, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   score <= '0;
    else if (!playing)            score <= '0;
    else if (st_q == DONE)        score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end
`else
  assign score = 16'd0;
`endif

endmodule
